// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with the
// carry held in a flop between digits. Start/busy/done handshake for the ALU.
//
//   state | meaning
//   IDLE  | waiting for start, result outputs hold last value
//   RUN   | one digit processed per clock, N = WIDTH/DIGIT clocks
//   DONE  | one-cycle done pulse, start here begins the next op directly
module serial_adder #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   input  logic             sub_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $fatal(1, "serial_adder: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [DIGIT-1:0] dsum;
   logic             cy;
   logic             dig_ctop;
   logic             dig_cout;
   logic             accept;

   // a start is only honoured when no digit work is in flight
   assign accept   = start_i && (state == IDLE || state == DONE);
   assign res_next = WIDTH'({dsum, res_sh} >> DIGIT);

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = RUN;
         RUN:     if (cnt == LAST) state_next = DONE;
         DONE:    state_next = start_i ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // handshake outputs are plain decodes of the registered state
   always_comb begin
      busy_o = (state == RUN);
      done_o = (state == DONE);
   end

   // ripple add of one digit; dig_ctop is the carry entering the digit's top bit
   always_comb begin : digit_add
      logic c;
      c        = cy;
      dsum     = '0;
      dig_ctop = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         dig_ctop = c;
         dsum[i]  = a_sh[i] ^ b_sh[i] ^ c;
         c        = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
      end
      dig_cout = c;
   end

   // operand shifters, digit carry, counter and result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         cy         <= 1'b0;
         cnt        <= '0;
         sum_o      <= '0;
         carry_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (accept) begin
         a_sh <= a_i;
         b_sh <= sub_i ? ~b_i : b_i;
         cy   <= sub_i ? 1'b1 : carry_i;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res_sh <= res_next;
         cy     <= dig_cout;
         cnt    <= cnt + 1'b1;
         if (cnt == LAST) begin
            sum_o      <= res_next;
            carry_o    <= dig_cout;
            overflow_o <= dig_ctop ^ dig_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit DIGIT=1 instance (index 0) and an 8-bit
// DIGIT=4 instance (index 1), checked against an arithmetic reference model.
module tb_serial_adder;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      start = '0;
   logic [1:0][7:0] a = '0;
   logic [1:0][7:0] b = '0;
   logic [1:0]      cin = '0;
   logic [1:0]      sub = '0;
   logic [1:0]      busy;
   logic [1:0]      done;
   logic [1:0][7:0] sum;
   logic [1:0]      cout;
   logic [1:0]      ovf;

   int asserts = 0;
   int fails   = 0;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       ci;
      logic       sb;
      logic [9:0] exp;
   } vec_t;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .a_i(a[0]), .b_i(b[0]),
      .carry_i(cin[0]), .sub_i(sub[0]), .busy_o(busy[0]), .done_o(done[0]),
      .sum_o(sum[0]), .carry_o(cout[0]), .overflow_o(ovf[0])
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .a_i(a[1]), .b_i(b[1]),
      .carry_i(cin[1]), .sub_i(sub[1]), .busy_o(busy[1]), .done_o(done[1]),
      .sum_o(sum[1]), .carry_o(cout[1]), .overflow_o(ovf[1])
   );

   // reference: {overflow, carry, sum} from plain integer arithmetic
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci, input logic sb);
      logic [7:0] ye;
      logic [8:0] r;
      logic       v;
      ye = sb ? ~y : y;
      r  = {1'b0, x} + {1'b0, ye} + (sb ? 9'd1 : {8'd0, ci});
      v  = (x[7] == ye[7]) && (r[7] != x[7]);
      return {v, r[8], r[7:0]};
   endfunction

   function automatic int lat(input int d);
      return (d == 0) ? 9 : 3;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int d, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic sb);
      a[d] = x; b[d] = y; cin[d] = ci; sub[d] = sb; start[d] = 1'b1;
      step();
      start[d] = 1'b0;
      a[d] = 8'($urandom); b[d] = 8'($urandom);
      cin[d] = 1'($urandom); sub[d] = 1'($urandom);
   endtask

   task automatic wait_done(input int d, output int cyc, output int nbusy);
      cyc = 1;
      nbusy = 0;
      while (done[d] !== 1'b1 && cyc < 40) begin
         if (busy[d] === 1'b1) nbusy++;
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 2'b11; a = '1; b = '1;
      step(); step();
      for (int d = 0; d < 2; d++) begin
         asserts++;
         if ({busy[d], done[d], ovf[d], cout[d], sum[d]} !== 12'h000) begin
            fails++;
            $display("FAIL reset d%0d: got busy=%b done=%b ovf=%b carry=%b sum=%h, want all 0",
                     d, busy[d], done[d], ovf[d], cout[d], sum[d]);
         end
      end
      rst = 1'b0; start = 2'b00;
      step();
   endtask

   task automatic test_basic();
      int cyc, nb;
      launch(0, 8'h35, 8'h4A, 1'b0, 1'b0);
      wait_done(0, cyc, nb);
      asserts++;
      if (cyc !== 9 || nb !== 8) begin
         fails++;
         $display("FAIL basic_timing: done cycle %0d busy cycles %0d, want 9 and 8", cyc, nb);
      end
      asserts++;
      if ({ovf[0], cout[0], sum[0]} !== 10'h07F || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: got %h busy=%b, want 07f busy=0",
                  {ovf[0], cout[0], sum[0]}, busy[0]);
      end
      step();
      asserts++;
      if (done[0] !== 1'b0 || sum[0] !== 8'h7F) begin
         fails++;
         $display("FAIL basic_pulse: done=%b sum=%h after done cycle, want 0 and 7f", done[0], sum[0]);
      end
   endtask

   task automatic test_boundaries();
      vec_t v[6] = '{
         '{8'hFF, 8'h01, 1'b0, 1'b0, 10'h100},
         '{8'h7F, 8'h01, 1'b0, 1'b0, 10'h280},
         '{8'h05, 8'h07, 1'b1, 1'b1, 10'h0FE},
         '{8'h80, 8'h01, 1'b1, 1'b1, 10'h37F},
         '{8'h10, 8'h20, 1'b1, 1'b0, 10'h031},
         '{8'h33, 8'h33, 1'b0, 1'b1, 10'h100}
      };
      int cyc, nb;
      for (int i = 0; i < 6; i++) begin
         launch(0, v[i].x, v[i].y, v[i].ci, v[i].sb);
         wait_done(0, cyc, nb);
         asserts++;
         if (cyc !== 9 || {ovf[0], cout[0], sum[0]} !== v[i].exp) begin
            fails++;
            $display("FAIL boundary[%0d]: got %h at cycle %0d, want %h at cycle 9",
                     i, {ovf[0], cout[0], sum[0]}, cyc, v[i].exp);
         end
         step();
      end
   endtask

   task automatic test_random();
      int cyc, nb;
      logic [7:0] x, y;
      logic ci, sb;
      logic [9:0] exp;
      for (int i = 0; i < 30; i++) begin
         int d = i % 2;
         x = 8'($urandom); y = 8'($urandom);
         ci = 1'($urandom); sb = 1'($urandom);
         exp = model(x, y, ci, sb);
         launch(d, x, y, ci, sb);
         wait_done(d, cyc, nb);
         asserts++;
         if (cyc !== lat(d) || {ovf[d], cout[d], sum[d]} !== exp) begin
            fails++;
            $display("FAIL random[%0d] d%0d %h %s %h ci=%b: got %h at cycle %0d, want %h at cycle %0d",
                     i, d, x, sb ? "-" : "+", y, ci, {ovf[d], cout[d], sum[d]}, cyc, exp, lat(d));
         end
         step();
      end
   endtask

   task automatic test_ignore_start();
      int cyc, nb;
      logic [9:0] exp;
      exp = model(8'h21, 8'h43, 1'b0, 1'b0);
      launch(0, 8'h21, 8'h43, 1'b0, 1'b0);
      step(); step(); step();
      a[0] = 8'hC0; b[0] = 8'h11; sub[0] = 1'b1; start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      wait_done(0, cyc, nb);
      asserts++;
      if (cyc + 4 !== 9 || {ovf[0], cout[0], sum[0]} !== exp) begin
         fails++;
         $display("FAIL ignore_start: got %h at cycle %0d, want %h at cycle 9",
                  {ovf[0], cout[0], sum[0]}, cyc + 4, exp);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int cyc, nb;
      logic stable;
      logic [9:0] r1, r2;
      r1 = model(8'h9C, 8'h25, 1'b1, 1'b0);
      r2 = model(8'h40, 8'h71, 1'b0, 1'b1);
      launch(0, 8'h9C, 8'h25, 1'b1, 1'b0);
      wait_done(0, cyc, nb);
      asserts++;
      if ({ovf[0], cout[0], sum[0]} !== r1) begin
         fails++;
         $display("FAIL b2b_first: got %h, want %h", {ovf[0], cout[0], sum[0]}, r1);
      end
      a[0] = 8'h40; b[0] = 8'h71; cin[0] = 1'b0; sub[0] = 1'b1; start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      asserts++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
         fails++;
         $display("FAIL b2b_accept: busy=%b done=%b, want 1 and 0", busy[0], done[0]);
      end
      cyc = 1;
      stable = 1'b1;
      while (done[0] !== 1'b1 && cyc < 40) begin
         if ({ovf[0], cout[0], sum[0]} !== r1) stable = 1'b0;
         step();
         cyc++;
      end
      asserts++;
      if (stable !== 1'b1) begin
         fails++;
         $display("FAIL b2b_hold: result changed during second op, want %h held", r1);
      end
      asserts++;
      if (cyc !== 9 || {ovf[0], cout[0], sum[0]} !== r2) begin
         fails++;
         $display("FAIL b2b_second: got %h at cycle %0d, want %h at cycle 9",
                  {ovf[0], cout[0], sum[0]}, cyc, r2);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int cyc, nb;
      logic seen;
      launch(0, 8'h12, 8'h34, 1'b0, 1'b0);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      asserts++;
      if ({busy[0], done[0], ovf[0], cout[0], sum[0]} !== 12'h000) begin
         fails++;
         $display("FAIL reset_mid: busy=%b done=%b ovf=%b carry=%b sum=%h, want all 0",
                  busy[0], done[0], ovf[0], cout[0], sum[0]);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done[0] === 1'b1 || busy[0] === 1'b1) seen = 1'b1;
         step();
      end
      asserts++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_quiet: busy/done seen after abort, want none");
      end
      launch(0, 8'hA5, 8'h5A, 1'b1, 1'b0);
      wait_done(0, cyc, nb);
      asserts++;
      if (cyc !== 9 || {ovf[0], cout[0], sum[0]} !== 10'h100) begin
         fails++;
         $display("FAIL reset_mid_fresh: got %h at cycle %0d, want 100 at cycle 9",
                  {ovf[0], cout[0], sum[0]}, cyc);
      end
      step();
   endtask

   task automatic test_digit4();
      int cyc, nb;
      launch(1, 8'hFF, 8'hFF, 1'b1, 1'b0);
      wait_done(1, cyc, nb);
      asserts++;
      if (cyc !== 3 || nb !== 2 || {ovf[1], cout[1], sum[1]} !== 10'h1FF) begin
         fails++;
         $display("FAIL digit4: got %h at cycle %0d busy %0d, want 1ff at cycle 3 busy 2",
                  {ovf[1], cout[1], sum[1]}, cyc, nb);
      end
      step();
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_boundaries();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_digit4();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Multi-cycle, parametrised N-bit adder/subtractor built around the one-bit adder cell. It processes DIGIT bits per clock, LSB-first, with carry held in a flip-flop between digits. This trades latency for area in the ALU datapath. A start/busy/done handshake lets the ALU control unit issue operations and wait for results.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH must be an integer multiple of DIGIT; otherwise elaboration fails with a fatal error.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request new operation; sampled only in IDLE or DONE
- a_i  input  WIDTH  operand A, captured on accepted start
- b_i  input  WIDTH  operand B, captured on accepted start
- carry_i  input  1  carry-in for add; ignored when sub_i=1
- sub_i  input  1  0 = A+B+carry_i; 1 = A-B (A + ~B + 1)
- busy_o  output  1  high while digits are being processed
- done_o  output  1  one-cycle pulse: result registers just updated
- sum_o  output  WIDTH  result
- carry_o  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow_o  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, digit counter=0, internal carry=0. busy_o=0, done_o=0, sum_o=0, carry_o=0, overflow_o=0. Reset overrides every other input, including start_i in the same cycle. Reset mid-RUN aborts the operation: no done_o pulse, outputs cleared.
- States: IDLE, RUN, DONE. N = WIDTH/DIGIT.
- IDLE:
  - start_i=1 at the edge → capture A, B_eff = sub_i ? ~b_i : b_i, and cin = sub_i ? 1 : carry_i into shift registers; counter=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each edge adds the low DIGIT bits of A and B_eff plus the carry register, ripple style inside the digit.
  - Shifts the digit result into the result shift register from the MSB side.
  - Stores the digit carry-out; counter += 1.
  - On the edge processing digit N-1:
    - record carry-into-MSB (the carry entering bit WIDTH-1) and carry-out;
    - load sum_o, carry_o and overflow_o from the completed result;
    - go to DONE.
  - start_i is ignored in RUN; no queuing.
- DONE: lasts exactly one cycle with done_o=1.
  - start_i=1 → accepted exactly as in IDLE; go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Timing: start sampled at edge 0 → busy_o=1 during cycles 1..N, done_o=1 during cycle N+1.
- Outputs: busy_o=(state==RUN) and done_o=(state==DONE), both registered-state decodes. sum_o, carry_o and overflow_o change only on the RUN→DONE edge or reset, and hold their values through IDLE and any following RUN.
- Operand inputs may change freely after the accepting edge without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
1. WIDTH=8, DIGIT=1; a=0x35, b=0x4A, carry_i=0, sub_i=0, start at edge 0 → busy_o high cycles 1-8, done_o only in cycle 9; sum_o=0x7F, carry_o=0, overflow_o=0.
2. Add boundaries: 0xFF+0x01, cin=0 → sum 0x00, carry 1, ovf 0. 0x7F+0x01 → sum 0x80, carry 0, ovf 1.
3. Subtract: 0x05-0x07 → sum 0xFE, carry_o 0 (borrow), ovf 0. 0x80-0x01 → sum 0x7F, carry 1, ovf 1. carry_i=1 during these has no effect.
4. Handshake:
   - start_i re-pulsed at cycle 4 with different operands → ignored; first result reported.
   - start_i held high in the done cycle → new op accepted, busy_o=1 in the next cycle, done_o again N+1 cycles later.
   - Previous sum_o stable throughout the second op.
5. rst_i asserted in cycle 4 of a RUN → cycle 5 shows busy_o=0, done_o never pulses, all outputs 0. A fresh start afterwards completes correctly.
6. WIDTH=8, DIGIT=4; 0xFF+0xFF, carry_i=1 → done_o in cycle 3; sum 0xFF, carry 1, ovf 0. WIDTH=8, DIGIT=3 → elaboration error.
